velocity_step_gen: RTL and testbench

//  Consumer side of the speed-level selector: converts a 0..MAX_LEVEL speed level into a

---
 rtl/velocity_step_gen.sv | 113 +++++++++++
 tb/tb_velocity_step_gen.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/velocity_step_gen.sv
// Converts a 0..MAX_LEVEL speed level into single-cycle step pulses whose rate doubles per level.
// Optional accel/decel ramp at step boundaries: define VELOCITY_RAMP_EN.
module velocity_step_gen #(
    parameter int unsigned LEVEL_W   = 3,
    parameter int unsigned MAX_LEVEL = 4,
    parameter int unsigned BASE_DIV  = 25_000_000,
    parameter int unsigned CNT_W     = 25
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [LEVEL_W-1:0] level,
    input  logic               en,
    output logic               step,
    output logic [LEVEL_W-1:0] cur_level,
    output logic               running,
    output logic [15:0]        step_cnt
);

    typedef enum logic {IDLE, RUN} state_t;

    localparam logic [LEVEL_W-1:0] MAX_L = LEVEL_W'(MAX_LEVEL);
    localparam logic [CNT_W-1:0]   BASE  = CNT_W'(BASE_DIV);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [LEVEL_W-1:0] cur_level_q, cur_level_d;
    logic               step_q, step_d;
    logic [15:0]        step_cnt_q, step_cnt_d;

    logic [LEVEL_W-1:0] lvl_c;
    logic [LEVEL_W-1:0] shamt;
    logic [CNT_W-1:0]   period_m1;
    logic [LEVEL_W-1:0] next_level;

    assign lvl_c     = (level > MAX_L) ? MAX_L : level;
    // Only meaningful in RUN, where cur_level_q >= 1.
    assign shamt     = cur_level_q - LEVEL_W'(1);
    assign period_m1 = (BASE >> shamt) - CNT_W'(1);

`ifdef VELOCITY_RAMP_EN
    always_comb begin
        next_level = lvl_c;
        if (cur_level_q < lvl_c)
            next_level = cur_level_q + LEVEL_W'(1);
        else if (cur_level_q > lvl_c)
            next_level = cur_level_q - LEVEL_W'(1);
    end
`else
    assign next_level = lvl_c;
`endif

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        cur_level_d = cur_level_q;
        step_d      = 1'b0;
        step_cnt_d  = step_cnt_q;
        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (en && (lvl_c != '0)) begin
                    state_d = RUN;
`ifdef VELOCITY_RAMP_EN
                    cur_level_d = LEVEL_W'(1);
`else
                    cur_level_d = lvl_c;
`endif
                end else begin
                    cur_level_d = '0;
                end
            end
            RUN: begin
                if (!en) begin
                    state_d     = IDLE;
                    cnt_d       = '0;
                    cur_level_d = '0;
                end else if (cnt_q == period_m1) begin
                    step_d      = 1'b1;
                    step_cnt_d  = step_cnt_q + 16'd1;
                    cnt_d       = '0;
                    cur_level_d = next_level;
                    if (next_level == '0)
                        state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            cur_level_q <= '0;
            step_q      <= 1'b0;
            step_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            cur_level_q <= cur_level_d;
            step_q      <= step_d;
            step_cnt_q  <= step_cnt_d;
        end
    end

    assign step      = step_q;
    assign cur_level = cur_level_q;
    assign running   = (state_q == RUN);
    assign step_cnt  = step_cnt_q;

endmodule

// File: tb/tb_velocity_step_gen.sv
// Randomized and directed bench for velocity_step_gen (BASE_DIV=16, MAX_LEVEL=4).
// A step-countdown reference model predicts every output each cycle.
module tb_velocity_step_gen;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [2:0]  level = '0;
    logic        en = 1'b0;
    logic        step;
    logic [2:0]  cur_level;
    logic        running;
    logic [15:0] step_cnt;

    int n_chk = 0;
    int n_fail = 0;

    // Reference model: time left until the next step, plus visible outputs.
    bit m_run, m_step;
    int m_lvl, m_left, m_cnt;

    velocity_step_gen #(
        .LEVEL_W(3),
        .MAX_LEVEL(4),
        .BASE_DIV(16),
        .CNT_W(5)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .level(level),
        .en(en),
        .step(step),
        .cur_level(cur_level),
        .running(running),
        .step_cnt(step_cnt)
    );

    always #5 clk = ~clk;

    function automatic int clampl(input int l);
        return (l > 4) ? 4 : l;
    endfunction

    function automatic int period(input int l);
        return 16 / (1 << (l - 1));
    endfunction

    task automatic model_reset();
        m_run = 0; m_step = 0; m_lvl = 0; m_left = 0; m_cnt = 0;
    endtask

    task automatic model_edge();
        int t, nl;
        t = clampl(int'(level));
        m_step = 0;
        if (!m_run) begin
            if (en && t != 0) begin
                m_run = 1;
`ifdef VELOCITY_RAMP_EN
                m_lvl = 1;
`else
                m_lvl = t;
`endif
                m_left = period(m_lvl);
            end else begin
                m_lvl = 0;
            end
        end else if (!en) begin
            m_run = 0;
            m_lvl = 0;
        end else begin
            m_left--;
            if (m_left == 0) begin
                m_step = 1;
                m_cnt = (m_cnt + 1) % 65536;
`ifdef VELOCITY_RAMP_EN
                nl = (m_lvl < t) ? m_lvl + 1 : (m_lvl > t) ? m_lvl - 1 : t;
`else
                nl = t;
`endif
                m_lvl = nl;
                if (nl == 0) m_run = 0;
                else m_left = period(nl);
            end
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_chk++;
        if ({step, cur_level, running, step_cnt} !== 21'd0) begin
            n_fail++;
            $display("FAIL reset_state: got step=%b lvl=%0d run=%b cnt=%0d, need all 0",
                     step, cur_level, running, step_cnt);
        end
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_level1();
        level = 3'd1; en = 1'b1;
        cycle();
        n_chk++;
        if (running !== 1'b1) begin
            n_fail++;
            $display("FAIL level1_running: got %b, need 1", running);
        end
        for (int i = 0; i < 80; i++) begin
            cycle();
            n_chk++;
            if ({step, cur_level, running, step_cnt} !== {m_step, 3'(m_lvl), m_run, 16'(m_cnt)}) begin
                n_fail++;
                $display("FAIL level1 cyc %0d: got step=%b lvl=%0d run=%b cnt=%0d need step=%b lvl=%0d run=%b cnt=%0d",
                         i, step, cur_level, running, step_cnt, m_step, m_lvl, m_run, m_cnt);
            end
        end
        n_chk++;
        if (step_cnt !== 16'd5) begin
            n_fail++;
            $display("FAIL level1_count: got %0d, need 5", step_cnt);
        end
    endtask

    task automatic test_level_change();
        for (int i = 0; i < 45; i++) begin
            if (i == 5) level = 3'd3;
            cycle();
            n_chk++;
            if ({step, cur_level, running, step_cnt} !== {m_step, 3'(m_lvl), m_run, 16'(m_cnt)}) begin
                n_fail++;
                $display("FAIL level_change cyc %0d: got step=%b lvl=%0d run=%b cnt=%0d need step=%b lvl=%0d run=%b cnt=%0d",
                         i, step, cur_level, running, step_cnt, m_step, m_lvl, m_run, m_cnt);
            end
        end
    endtask

    task automatic test_clamp();
        level = 3'd7;
        for (int i = 0; i < 24; i++) begin
            cycle();
            n_chk++;
            if ({step, cur_level, running, step_cnt} !== {m_step, 3'(m_lvl), m_run, 16'(m_cnt)}) begin
                n_fail++;
                $display("FAIL clamp cyc %0d: got step=%b lvl=%0d run=%b cnt=%0d need step=%b lvl=%0d run=%b cnt=%0d",
                         i, step, cur_level, running, step_cnt, m_step, m_lvl, m_run, m_cnt);
            end
        end
        n_chk++;
        if (cur_level !== 3'd4) begin
            n_fail++;
            $display("FAIL clamp_level: got %0d, need 4", cur_level);
        end
    endtask

    task automatic test_stop();
        en = 1'b0;
        cycle();
        level = 3'd2; en = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (i == 4) level = 3'd0;
            cycle();
            n_chk++;
            if ({step, cur_level, running, step_cnt} !== {m_step, 3'(m_lvl), m_run, 16'(m_cnt)}) begin
                n_fail++;
                $display("FAIL stop cyc %0d: got step=%b lvl=%0d run=%b cnt=%0d need step=%b lvl=%0d run=%b cnt=%0d",
                         i, step, cur_level, running, step_cnt, m_step, m_lvl, m_run, m_cnt);
            end
        end
        // Drop en exactly on the boundary cycle of a level-1 period.
        level = 3'd1;
        cycle();
        for (int i = 0; i < 15; i++) cycle();
        en = 1'b0;
        cycle();
        n_chk++;
        if ({step, running} !== 2'b00 || {step, cur_level, running, step_cnt} !== {m_step, 3'(m_lvl), m_run, 16'(m_cnt)}) begin
            n_fail++;
            $display("FAIL en_boundary: got step=%b run=%b lvl=%0d cnt=%0d need step=0 run=0 lvl=%0d cnt=%0d",
                     step, running, cur_level, step_cnt, m_lvl, m_cnt);
        end
    endtask

`ifdef VELOCITY_RAMP_EN
    task automatic test_ramp();
        en = 1'b0;
        cycle();
        level = 3'd4; en = 1'b1;
        cycle();
        for (int i = 0; i < 28; i++) begin
            cycle();
            n_chk++;
            if ({step, cur_level, running, step_cnt} !== {m_step, 3'(m_lvl), m_run, 16'(m_cnt)}) begin
                n_fail++;
                $display("FAIL ramp cyc %0d: got step=%b lvl=%0d run=%b cnt=%0d need step=%b lvl=%0d run=%b cnt=%0d",
                         i, step, cur_level, running, step_cnt, m_step, m_lvl, m_run, m_cnt);
            end
        end
        n_chk++;
        if (cur_level !== 3'd4) begin
            n_fail++;
            $display("FAIL ramp_level: got %0d, need 4", cur_level);
        end
    endtask
`endif

    task automatic test_reset_midrun();
        level = 3'd2; en = 1'b1;
        for (int i = 0; i < 13; i++) cycle();
        #3 rst_n = 1'b0;
        #1;
        n_chk++;
        if ({step, cur_level, running, step_cnt} !== 21'd0) begin
            n_fail++;
            $display("FAIL reset_midrun: got step=%b lvl=%0d run=%b cnt=%0d, need all 0",
                     step, cur_level, running, step_cnt);
        end
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_random();
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 19) == 0) level = 3'($urandom_range(0, 7));
            en = ($urandom_range(0, 39) != 0);
            if ($urandom_range(0, 299) == 0) begin
                #2 rst_n = 1'b0;
                #1;
                n_chk++;
                if ({step, cur_level, running, step_cnt} !== 21'd0) begin
                    n_fail++;
                    $display("FAIL random_reset cyc %0d: got step=%b lvl=%0d run=%b cnt=%0d, need all 0",
                             i, step, cur_level, running, step_cnt);
                end
                rst_n = 1'b1;
                model_reset();
            end
            cycle();
            n_chk++;
            if ({step, cur_level, running, step_cnt} !== {m_step, 3'(m_lvl), m_run, 16'(m_cnt)}) begin
                n_fail++;
                $display("FAIL random cyc %0d: got step=%b lvl=%0d run=%b cnt=%0d need step=%b lvl=%0d run=%b cnt=%0d",
                         i, step, cur_level, running, step_cnt, m_step, m_lvl, m_run, m_cnt);
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_level1();
        test_level_change();
        test_clamp();
        test_stop();
`ifdef VELOCITY_RAMP_EN
        test_ramp();
`endif
        test_reset_midrun();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
